// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 single-LED serial driver.
// Timing defaults assume a 27 MHz clock.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int T0H_CYC_DEF   = 10;
  localparam int T1H_CYC_DEF   = 19;
  localparam int BIT_CYC_DEF   = 34;
  localparam int RESET_CYC_DEF = 8100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_driver.sv
// WS2812 driver: streams one 24-bit GRB word MSB first, then holds the line
// low for the latch gap; repeats while ena is high.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC   = T0H_CYC_DEF,
  parameter int T1H_CYC   = T1H_CYC_DEF,
  parameter int BIT_CYC   = BIT_CYC_DEF,
  parameter int RESET_CYC = RESET_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       ws2812_o
);

  localparam int CW = $clog2(max_int(BIT_CYC, RESET_CYC));
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] TH0      = CW'(T0H_CYC);
  localparam logic [CW-1:0] TH1      = CW'(T1H_CYC);

  state_t          r_state, w_state_nxt;
  logic [23:0]     r_shift, w_shift_nxt;
  logic [4:0]      r_idx,   w_idx_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic            w_out_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      ws2812_o <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      ws2812_o <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (ena) begin
          w_shift_nxt = {g, r, b};
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = BIT;
        end
      end
      BIT: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == 5'd23) begin
            w_state_nxt = GAP;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_shift_nxt = {r_shift[22:0], 1'b0};
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output is decided from next-cycle state so the line is a clean register.
  assign w_out_nxt = (w_state_nxt == BIT) &&
                     (w_cnt_nxt < (w_shift_nxt[23] ? TH1 : TH0));

endmodule

// File: tb/tb_ws2812_driver.sv
// Self-checking bench for ws2812_driver: pulse-width scoreboard plus a
// table of back-to-back frames and hand-written reset/ena corner cases.
module tb_ws2812_driver;

  localparam int T0H       = 10;
  localparam int T1H       = 19;
  localparam int BITC      = 34;
  localparam int RSTC      = 8100;
  localparam int FRAME_GAP = BITC + RSTC + 1;
  localparam int FRAME_PER = 24 * BITC + RSTC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] r, g, b;
  logic       ws2812_o;

  ws2812_driver dut (
    .clk(clk), .rst(rst), .ena(ena), .r(r), .g(g), .b(b), .ws2812_o(ws2812_o)
  );

  always #5 clk = ~clk;

  typedef struct {int hi; int dprev; bit first;} exp_t;
  typedef struct {logic [23:0] grb; int ones;} vec_t;

  exp_t exp_q[$];
  int   frame_rise_q[$];
  vec_t tbl[4];

  int   n_pass = 0, n_tot = 0;
  int   cyc = 0, last_rise = 0, pulse_cnt = 0, long_cnt = 0, hi_cycles = 0, hi = 0;
  logic prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: measures high time and rise-to-rise spacing of every pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev = 1'b0;
      hi   = 0;
    end else begin
      if (ws2812_o) hi_cycles++;
      if (ws2812_o && !prev) begin
        chk("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          if (exp_q[0].dprev != 0) chk("rise_spacing", cyc - last_rise, exp_q[0].dprev);
          if (exp_q[0].first) frame_rise_q.push_back(cyc);
        end
        last_rise = cyc;
        hi = 1;
      end else if (ws2812_o) begin
        hi++;
      end
      if (!ws2812_o && prev) begin
        pulse_cnt++;
        if (hi >= T1H) long_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("high_time", hi, e.hi);
        end
      end
      prev = ws2812_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [23:0] grb, input int d0);
    for (int i = 23; i >= 0; i--)
      exp_q.push_back('{hi: grb[i] ? T1H : T0H, dprev: (i == 23) ? d0 : BITC, first: (i == 23)});
  endtask

  task automatic wait_pulses(input int target, input int budget, input string nm);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk(nm, pulse_cnt, target);
  endtask

  task automatic wait_rise(input int t_en);
    int n = 0;
    while (last_rise <= t_en && n < 100) begin
      step(1);
      n++;
    end
    chk("start_latency", last_rise - t_en, 1);
  endtask

  initial begin
    int h0, t_en, base, lb;
    tbl[0] = '{grb: 24'h800001, ones: 2};
    tbl[1] = '{grb: 24'hFFFFFF, ones: 24};
    tbl[2] = '{grb: 24'h000000, ones: 0};
    tbl[3] = '{grb: 24'hA5C33C, ones: 12};

    rst = 1'b1;
    ena = 1'b1;
    {g, r, b} = tbl[0].grb;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset_hold", int'(ws2812_o), 0);
    end

    rst = 1'b0;
    ena = 1'b0;
    h0 = hi_cycles;
    step(10000);
    chk("idle_low", hi_cycles - h0, 0);

    // Continuous frames; next word is presented mid-frame at bit 5.
    push_frame(tbl[0].grb, 0);
    {g, r, b} = tbl[0].grb;
    ena  = 1'b1;
    t_en = cyc;
    wait_rise(t_en);
    for (int k = 0; k < 4; k++) begin
      base = pulse_cnt;
      lb   = long_cnt;
      if (k < 3) begin
        wait_pulses(base + 4, 10000, "reach_bit5");
        {g, r, b} = tbl[k + 1].grb;
        push_frame(tbl[k + 1].grb, FRAME_GAP);
      end else begin
        wait_pulses(base + 9, 10000, "reach_bit10");
        ena = 1'b0;
      end
      wait_pulses(base + 24, 2000, "frame_bits");
      chk("frame_ones", long_cnt - lb, tbl[k].ones);
      if (k > 0)
        chk("frame_period",
            (frame_rise_q.size() > k) ? frame_rise_q[k] - frame_rise_q[k - 1] : -1, FRAME_PER);
    end

    h0 = hi_cycles;
    step(8300);
    chk("gap_after_ena_drop", hi_cycles - h0, 0);
    chk("sb_empty", exp_q.size(), 0);

    // Reset in the middle of a high phase, then restart without a gap.
    {g, r, b} = 24'hFFFFFF;
    push_frame(24'hFFFFFF, 0);
    ena  = 1'b1;
    t_en = cyc;
    wait_rise(t_en);
    step(8);
    chk("mid_bit_high", int'(ws2812_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", int'(ws2812_o), 0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset_mid_hold", int'(ws2812_o), 0);
    end

    rst  = 1'b0;
    base = pulse_cnt;
    lb   = long_cnt;
    push_frame(tbl[0].grb, 0);
    {g, r, b} = tbl[0].grb;
    t_en = cyc;
    wait_rise(t_en);
    wait_pulses(base + 24, 1000, "restart_bits");
    chk("restart_ones", long_cnt - lb, tbl[0].ones);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ws2812_driver.md
WS2812_DRIVER -- requirements
Module: ws2812_driver

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be rst, asynchronous and active-high.
REQ-002 Parameter T0H_CYC, default 10: high time of a 0 bit, in clk cycles (0.37 us at 27 MHz).
REQ-003 Parameter T1H_CYC, default 19: high time of a 1 bit, in clk cycles (0.70 us at 27 MHz).
REQ-004 Parameter BIT_CYC, default 34: total period of one bit, in clk cycles (1.26 us at 27 MHz).
REQ-005 Parameter RESET_CYC, default 8100: low latch gap after each frame, in clk cycles (300 us at 27 MHz).
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port ena, input, 1: high means refresh the LED continuously; low means the line stays idle.
REQ-009 Port r, input, 8: red intensity.
REQ-010 Port g, input, 8: green intensity.
REQ-011 Port b, input, 8: blue intensity.
REQ-012 Port ws2812_o, output, 1: serial data line to the LED; registered; idle level is low.

Function
REQ-013 The FSM SHALL have three states: IDLE, BIT and GAP.
REQ-014 In IDLE, on a clock edge where ena=1, the block SHALL:
- latch the 24-bit word {g,r,b} into a shift register;
- set the bit index to 0 and the cycle counter to 0;
- enter BIT.
REQ-015 The word SHALL be sent in GRB order, MSB first: g[7] first and b[0] last.
REQ-016 Each bit SHALL last exactly BIT_CYC cycles; ws2812_o SHALL be high for the first TH cycles and low for the rest.
- TH = T1H_CYC when the current bit is 1.
- TH = T0H_CYC when the current bit is 0.
REQ-017 ws2812_o SHALL first go high in the cycle that follows the IDLE edge where ena was sampled high.
REQ-018 Bits SHALL be sent back-to-back, with no gap cycles between them.
REQ-019 After bit 24, the block SHALL enter GAP and hold ws2812_o low for exactly RESET_CYC cycles, then return to IDLE.
REQ-020 r, g and b SHALL be sampled only at frame start; changing them mid-frame SHALL NOT affect the frame in progress.
REQ-021 ena SHALL be examined only in IDLE.
- Deasserting ena mid-frame lets the current frame and its GAP complete.
- With ena held high, frames repeat every 24*BIT_CYC + RESET_CYC + 1 cycles (the +1 is the IDLE cycle).
REQ-022 With ena=0 in IDLE, ws2812_o SHALL stay low indefinitely.
REQ-023 The cycle counter SHALL be $clog2(max(BIT_CYC,RESET_CYC)) bits wide.
- It SHALL wrap to 0 at each bit boundary and at the end of GAP.
REQ-024 Parameters SHALL satisfy 0 < T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 1; other values are unsupported.

Reset
REQ-025 While rst=1, the block SHALL hold:
- ws2812_o = 0 and state = IDLE;
- the shift register, bit index and counter at 0.
REQ-026 Reset asserted mid-frame SHALL force ws2812_o low immediately, without waiting for a clock edge.
REQ-027 After rst deasserts, the next frame SHALL start from IDLE per REQ-014, with no GAP first.

Structure
REQ-028 The FSM state enum and the default timing constants SHALL live in the shared package ws2812_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the expected size is about 120-200 lines of RTL.

Verification
REQ-030 Reset: hold rst=1 for 5 cycles with ena=1 -> ws2812_o=0 throughout; assert rst in mid-bit -> ws2812_o drops to 0 the same cycle.
REQ-031 Frame shape: ena=1, g=0x80, r=0x00, b=0x01, defaults ->
- bit 1: 19 cycles high, 15 low;
- bits 2-23: 10 cycles high, 24 low each;
- bit 24: 19 cycles high, 15 low;
- then 8100 cycles low.
REQ-032 Idle: ena=0 for 10000 cycles -> ws2812_o constantly 0.
REQ-033 Data stability: change {g,r,b} from 0xFFFFFF to 0x000000 at bit 5 ->
- current frame shows 24 one-bits (19 cycles high each);
- next frame shows 24 zero-bits (10 cycles high each).
REQ-034 ena drop: deassert ena at bit 10 -> frame completes all 24 bits and the 8100-cycle GAP, then the line stays low.
REQ-035 Repeat rate: ena held high -> rising edges of consecutive frames are exactly 24*34 + 8100 + 1 = 8917 cycles apart.
